// File: rtl/line_steering_ctrl.sv
// Line-following steering controller: reads a tape-sensor bar and sequences track
// duties and H-bridge direction through launch, tracking, corner confirm, turn and hold states.
module line_steering_ctrl #(
    parameter int N_SENS      = 4,
    parameter int DUTY_W      = 20,
    parameter int DUTY_LAUNCH = 125000,
    parameter int DUTY_CRUISE = 90000,
    parameter int DUTY_CONFIRM = 100000,
    parameter int DUTY_PIVOT  = 250000,
    parameter int DUTY_MIN    = 1,
    parameter int CONFIRM_CYC = 27500000,
    parameter int LOST_CYC    = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SENS-1:0] ips,
    input  logic              ir_stop,
    input  logic              oc_flag,
    input  logic              done,
    output logic [DUTY_W-1:0] duty_a,
    output logic [DUTY_W-1:0] duty_b,
    output logic [3:0]        dir,
    output logic [2:0]        state,
    output logic              fault
);

    // state    | meaning
    // LAUNCH   | waiting on start bar, drive forward while all sensors see tape
    // TRACK    | steering on the sensor pattern
    // CONFIRM  | all sensors on tape, timing whether this is a real corner marker
    // TURN     | pivoting left until re-centred or mission done
    // HOLD_IR  | stopped for obstacle
    // HOLD_OC  | stopped for overcurrent
    // LOST     | no tape seen, coasting on last command until timeout
    // HALT     | stopped until reset
    typedef enum logic [2:0] {
        S_LAUNCH  = 3'd0,
        S_TRACK   = 3'd1,
        S_CONFIRM = 3'd2,
        S_TURN    = 3'd3,
        S_HOLD_IR = 3'd4,
        S_HOLD_OC = 3'd5,
        S_LOST    = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    localparam logic [3:0] DIR_FWD   = 4'b1001;
    localparam logic [3:0] DIR_LEFT  = 4'b1010;
    localparam logic [3:0] DIR_RIGHT = 4'b0101;
    localparam logic [3:0] DIR_STOP  = 4'b0000;

    localparam int HALF = N_SENS / 2;
    localparam logic [N_SENS-1:0] ONE     = {{(N_SENS-1){1'b0}}, 1'b1};
    localparam logic [N_SENS-1:0] L_INNER = ONE << (HALF - 1);
    localparam logic [N_SENS-1:0] R_INNER = ONE << HALF;

    localparam logic [DUTY_W-1:0] D_LAUNCH  = DUTY_W'(DUTY_LAUNCH);
    localparam logic [DUTY_W-1:0] D_CRUISE  = DUTY_W'(DUTY_CRUISE);
    localparam logic [DUTY_W-1:0] D_CONFIRM = DUTY_W'(DUTY_CONFIRM);
    localparam logic [DUTY_W-1:0] D_PIVOT   = DUTY_W'(DUTY_PIVOT);
    localparam logic [DUTY_W-1:0] D_MIN     = DUTY_W'(DUTY_MIN);

    localparam logic [31:0] CONFIRM_LAST = 32'(CONFIRM_CYC - 1);
    localparam logic [31:0] LOST_LAST    = 32'(LOST_CYC - 1);

    state_t state_q, state_d;
    logic [31:0] confirm_cnt, confirm_cnt_d;
    logic [31:0] lost_cnt, lost_cnt_d;
    logic [3:0]  dir_d;
    logic [DUTY_W-1:0] duty_a_d, duty_b_d;
    logic fault_d;

    logic [3:0] pop_l, pop_r;
    logic all_on, none_on, centred, only_l, only_r;

    always_comb begin
        pop_l = '0;
        pop_r = '0;
        for (int i = 0; i < HALF; i++) begin
            pop_l = pop_l + 4'(ips[i]);
            pop_r = pop_r + 4'(ips[i+HALF]);
        end
        all_on  = &ips;
        none_on = ~|ips;
        centred = (ips == (L_INNER | R_INNER));
        only_l  = (ips == L_INNER);
        only_r  = (ips == R_INNER);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_LAUNCH;
            confirm_cnt <= '0;
            lost_cnt    <= '0;
            dir         <= DIR_STOP;
            duty_a      <= '0;
            duty_b      <= '0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            confirm_cnt <= confirm_cnt_d;
            lost_cnt    <= lost_cnt_d;
            dir         <= dir_d;
            duty_a      <= duty_a_d;
            duty_b      <= duty_b_d;
            fault       <= fault_d;
        end
    end

    assign state = state_q;

    // Safety flags outrank every other transition in the moving states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LAUNCH: if (centred) state_d = S_TRACK;
            S_TRACK, S_CONFIRM, S_TURN, S_LOST: begin
                if (oc_flag)      state_d = S_HOLD_OC;
                else if (ir_stop) state_d = S_HOLD_IR;
                else begin
                    case (state_q)
                        S_TRACK: begin
                            if (all_on)       state_d = S_CONFIRM;
                            else if (none_on) state_d = S_LOST;
                        end
                        S_CONFIRM: begin
                            if (!all_on)                          state_d = S_TRACK;
                            else if (confirm_cnt == CONFIRM_LAST) state_d = S_TURN;
                        end
                        S_TURN: begin
                            if (done)         state_d = S_HALT;
                            else if (centred) state_d = S_TRACK;
                        end
                        S_LOST: begin
                            if (!none_on)                 state_d = S_TRACK;
                            else if (lost_cnt == LOST_LAST) state_d = S_HALT;
                        end
                        default: ;
                    endcase
                end
            end
            S_HOLD_OC: if (!oc_flag) state_d = S_TRACK;
            S_HOLD_IR: begin
                if (oc_flag)      state_d = S_HOLD_OC;
                else if (!ir_stop) state_d = S_TRACK;
            end
            S_HALT: ;
            default: state_d = S_LAUNCH;
        endcase

        confirm_cnt_d = (state_q == S_CONFIRM && state_d == S_CONFIRM) ? confirm_cnt + 32'd1 : '0;
        lost_cnt_d    = (state_q == S_LOST && state_d == S_LOST) ? lost_cnt + 32'd1 : '0;
    end

    // Command follows the state being entered, so it lines up with the state output.
    always_comb begin
        dir_d    = dir;
        duty_a_d = duty_a;
        duty_b_d = duty_b;
        fault_d  = fault | (state_q == S_LOST && state_d == S_HALT);
        case (state_d)
            S_LAUNCH: begin
                if (all_on) begin
                    dir_d    = DIR_FWD;
                    duty_a_d = D_LAUNCH;
                    duty_b_d = D_LAUNCH;
                end
            end
            S_TRACK: begin
                if (state_q == S_TRACK) begin
                    if (only_l) begin
                        dir_d    = DIR_FWD;
                        duty_a_d = D_MIN;
                        duty_b_d = D_PIVOT;
                    end else if (only_r) begin
                        dir_d    = DIR_FWD;
                        duty_a_d = D_PIVOT;
                        duty_b_d = D_MIN;
                    end else if (centred) begin
                        dir_d    = DIR_FWD;
                        duty_a_d = D_CRUISE;
                        duty_b_d = D_CRUISE;
                    end else if (pop_l > pop_r) begin
                        dir_d    = DIR_LEFT;
                        duty_a_d = D_PIVOT;
                        duty_b_d = D_PIVOT;
                    end else if (pop_r > pop_l) begin
                        dir_d    = DIR_RIGHT;
                        duty_a_d = D_PIVOT;
                        duty_b_d = D_PIVOT;
                    end
                end
            end
            S_CONFIRM: begin
                dir_d    = DIR_FWD;
                duty_a_d = D_CONFIRM;
                duty_b_d = D_CONFIRM;
            end
            S_TURN: begin
                dir_d    = DIR_LEFT;
                duty_a_d = D_PIVOT;
                duty_b_d = D_PIVOT;
            end
            S_HOLD_IR, S_HOLD_OC, S_HALT: begin
                dir_d    = DIR_STOP;
                duty_a_d = D_MIN;
                duty_b_d = D_MIN;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/line_steering_ctrl.md
LINE_STEERING_CTRL -- requirements
Module: line_steering_ctrl

Interface
REQ-001 Parameter N_SENS, default 4: sensor count; even, 4..8; bit 0 leftmost; inner pair = bits N_SENS/2-1 (left inner) and N_SENS/2 (right inner).
REQ-002 Parameter DUTY_W, default 20: duty output width.
REQ-003 Parameters DUTY_LAUNCH 125000, DUTY_CRUISE 90000, DUTY_CONFIRM 100000, DUTY_PIVOT 250000, DUTY_MIN 1: duty values in clk counts.
REQ-004 Parameters CONFIRM_CYC 27500000, LOST_CYC 50000000: cycle limits, both >= 2.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset; synchronous, active-low.
REQ-007 ips  input  N_SENS  1 = sensor over tape.
REQ-008 ir_stop  input  1  obstacle/IR stop request, level.
REQ-009 oc_flag  input  1  overcurrent flag, level.
REQ-010 done  input  1  mission complete, level.
REQ-011 duty_a  output  DUTY_W  left track duty; duty_b  output  DUTY_W  right track duty.
REQ-012 dir  output  4  H-bridge code: FWD 1001, BWD 0110, LEFT 1010, RIGHT 0101, STOP 0000.
REQ-013 state  output  3  current state encoding; fault  output  1  lost-line fault.

Function
REQ-014 All outputs registered; command reflects inputs sampled on previous edge (1-cycle latency).
REQ-015 States: LAUNCH 0, TRACK 1, CONFIRM 2, TURN 3, HOLD_IR 4, HOLD_OC 5, LOST 6, HALT 7.
REQ-016 Terms: ALL = every ips bit 1; NONE = every bit 0; CENTRED = both inner 1, no outer bit; L/R = popcount of left/right half.
REQ-017 "STOP command" = dir STOP, duty_a = duty_b = DUTY_MIN.
REQ-018 LAUNCH: ALL -> FWD, DUTY_LAUNCH both; CENTRED -> TRACK; otherwise hold outputs; ir_stop/oc_flag ignored.
REQ-019 TRACK steering, first match wins: ALL -> CONFIRM; NONE -> LOST; only left inner set -> FWD, duty_a DUTY_MIN, duty_b DUTY_PIVOT; only right inner set -> FWD, duty_a DUTY_PIVOT, duty_b DUTY_MIN; CENTRED -> FWD, DUTY_CRUISE both; L>R -> LEFT, DUTY_PIVOT both; R>L -> RIGHT, DUTY_PIVOT both; L==R -> hold outputs.
REQ-020 In TRACK, CONFIRM, TURN, LOST: oc_flag=1 -> HOLD_OC; else ir_stop=1 -> HOLD_IR; this check overrides all other transitions that cycle.
REQ-021 HOLD_OC / HOLD_IR: STOP command; exit to TRACK on the cycle its own flag reads 0; oc_flag asserted in HOLD_IR -> HOLD_OC.
REQ-022 CONFIRM: FWD, DUTY_CONFIRM both; counter +1 per cycle; pattern != ALL -> TRACK; counter == CONFIRM_CYC-1 with ALL -> TURN; counter cleared on every CONFIRM exit.
REQ-023 TURN: LEFT, DUTY_PIVOT both; done=1 -> HALT; else CENTRED -> TRACK; done wins over CENTRED.
REQ-024 LOST: hold last TRACK command; lost counter +1 per cycle; any ips bit 1 -> TRACK, counter cleared; counter == LOST_CYC-1 -> HALT with fault=1.
REQ-025 HALT: STOP command; exits only via reset; fault holds its value.
REQ-026 Counters 32-bit, saturate-free since limits bound them; never wrap.

Reset
REQ-027 rst_n=0 at edge: state LAUNCH, dir STOP, duty_a = duty_b = 0, fault 0, both counters 0; reset mid-operation overrides every transition.

Verification
REQ-028 N_SENS=4: reset, ips 1111 for 3 cycles -> dir 1001, duties 125000; ips 0110 -> state TRACK, next cycle duties 90000.
REQ-029 TRACK, ips 0100 (bit2 only) -> dir 1001, duty_a 250000, duty_b 1; ips 1100 -> dir 0101, duties 250000.
REQ-030 CONFIRM_CYC=8: TRACK, ips 1111 held 8 cycles -> TURN, dir 1010; ips 1111 for 4 cycles then 0110 -> TRACK, counter 0.
REQ-031 TRACK, ir_stop=1 and oc_flag=1 same cycle -> HOLD_OC, STOP command; drop oc_flag with ir_stop=1 -> TRACK then HOLD_IR.
REQ-032 LOST_CYC=16: TRACK, ips 0000 16 cycles -> HALT, fault 1, STOP command; ips 0110 afterwards -> stays HALT.
REQ-033 TURN with done=1 and ips 0110 same cycle -> HALT, fault 0; N_SENS=6 rerun of REQ-028 with 111111/001100.
